mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Single-port memory arbiter for the pipelined CPU. It shares one unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Fixed priority goes to data accesses, with a starvation guard for fetches.
- Each access runs for a parameterised number of cycles.
- It returns read data or a write acknowledge through a valid pulse.
- The pipeline controller uses the inverted grants as IF/MEM stall sources.

Parameters:
ADDR_W, 10, word address width of the shared memory
DATA_W, 32, data word width
MEM_LAT, 1, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..7
STARVE_MAX, 4, consecutive lost IF arbitrations before IF is forced to win once; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held with stable if_addr until if_gnt
if_addr  in  ADDR_W  fetch word address
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  DATA_W  fetched instruction
dm_req  in  1  data request; held with stable dm_we/dm_addr/dm_wdata until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data word address
dm_wdata  in  DATA_W  store data
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  one-cycle pulse: load data valid, or store done
dm_rdata  out  DATA_W  load data; 0 for stores
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
Reset and interface
- One clock (clk). Reset rst is synchronous and active-high.
- While rst=1: state=IDLE, lat_cnt=0, starve_cnt=0, owner=NONE.
- While rst=1, every output is 0, including combinational grants and mem_en.

State machine (2 states)
- IDLE:
  - Arbitrate when at least one request is present. Grant is combinational in the same cycle.
  - mem_en=1 in that cycle. mem_we, mem_addr and mem_wdata come from the winner.
  - The winner is recorded in owner. Move to BUSY with lat_cnt=1.
- BUSY:
  - mem_en=0 and both gnt=0.
  - lat_cnt increments each cycle.
  - In the cycle where lat_cnt==MEM_LAT (counted from the grant cycle):
    - pulse the owner's rvalid;
    - drive the owner's rdata from mem_rdata, or 0 for a store;
    - return to IDLE.
  - No grant is given in the rvalid cycle.
  - Back-to-back throughput is therefore one access per MEM_LAT+1 cycles.
- The rdata of a non-owner, and any rdata outside its rvalid cycle, is 0.

Arbitration in IDLE
- Only dm_req: DM wins. Only if_req: IF wins.
- Both requesting:
  - DM wins unless starve_cnt==STARVE_MAX, in which case IF wins.
- starve_cnt:
  - increments (saturating at STARVE_MAX) on an IDLE grant to DM while if_req=1;
  - clears on an IF grant, or on any IDLE cycle with if_req=0;
  - holds in BUSY.
- A requester may drop req before its grant with no effect. No grant is issued with no request.
- Requests are sampled only in IDLE. A request arriving during BUSY waits.

Other rules
- A store is acknowledged by dm_rvalid. Stores and loads use the same latency.
- Reset asserted mid-access (BUSY) aborts it: no rvalid is produced, and the memory result is discarded.
- Only IF and DM exist, so no owner can be granted twice concurrently. An assertion checks that if_gnt & dm_gnt is never 1.

Decomposition:
- Shared package arb_pkg:
  - typedef enum owner_t {NONE, IF_PORT, DM_PORT};
  - typedef enum arb_state_t {IDLE, BUSY};
  - width constants for lat_cnt (3 bits) and starve_cnt (4 bits).
- No sub-module. Arbitration, the counter and the FSM fit in one module (about 150–200 lines).

Test Plan:
- Reset: hold rst 3 cycles with both reqs high -> all outputs 0. First grant occurs in the first cycle after rst falls.
- IF only, MEM_LAT=1, if_addr=0x004, mem_rdata=0x8C000005 -> if_gnt and mem_en in cycle t; if_rvalid=1 with if_rdata=0x8C000005 at t+1; next if_gnt at t+2.
- Store with MEM_LAT=3: dm_we=1, dm_addr=0x010, dm_wdata=0x0000002A -> mem_we=1, mem_wdata=0x2A at t; dm_rvalid=1 and dm_rdata=0 at t+3.
- Conflict: both reqs held continuously, MEM_LAT=1, STARVE_MAX=4 -> grant order DM, DM, DM, DM, IF, DM, DM, DM, DM, IF. Grants every 2 cycles.
- Starve clear: IF req with DM winning twice, then if_req drops 1 IDLE cycle and is reasserted -> starve_cnt=0, and four more DM wins are needed before IF is forced.
- Mid-access reset: DM load granted with MEM_LAT=3, rst pulsed at t+1 -> no dm_rvalid at t+3; state is IDLE, with a grant again in the first cycle after rst falls.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and counter widths for the IF/DM memory port arbiter.
package arb_pkg;

  // Which requester owns the access currently in flight
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    IF_PORT = 2'd1,
    DM_PORT = 2'd2
  } owner_t;

  // IDLE arbitrates and launches; BUSY waits out the memory latency
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // lat_cnt must reach MEM_LAT (max 7); starve_cnt must reach STARVE_MAX (max 15)
  localparam int LAT_CNT_W    = 3;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (IF) and the data
// stage (DM). Data accesses win by default; a fetch that keeps losing is
// forced through once its loss count reaches STARVE_MAX. One access is in
// flight at a time and completes MEM_LAT cycles after its grant.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t              state_reg;
  owner_t                  owner_reg;
  logic                    store_reg;
  logic [LAT_CNT_W-1:0]    lat_cnt_reg;
  logic [STARVE_CNT_W-1:0] starve_cnt_reg;

  logic idle_arb;
  logic starved;
  logic pick_if;
  logic grant_if;
  logic grant_dm;
  logic done;

  // Arbitration decision and completion detect; reset masks everything so
  // no grant or strobe can escape while rst is high
  always_comb begin
    idle_arb = !rst && (state_reg == IDLE);
    starved  = (starve_cnt_reg == STARVE_CNT_W'(STARVE_MAX));
    pick_if  = if_req && (!dm_req || starved);
    grant_if = idle_arb && pick_if;
    grant_dm = idle_arb && dm_req && !pick_if;
    done     = !rst && (state_reg == BUSY) && (lat_cnt_reg == LAT_CNT_W'(MEM_LAT));
  end

  // Memory strobe and response routing; rdata is forced to 0 outside rvalid
  always_comb begin
    if_gnt    = grant_if;
    dm_gnt    = grant_dm;
    mem_en    = grant_if || grant_dm;
    mem_we    = grant_dm && dm_we;
    mem_addr  = grant_dm ? dm_addr : (grant_if ? if_addr : '0);
    mem_wdata = (grant_dm && dm_we) ? dm_wdata : '0;
    if_rvalid = done && (owner_reg == IF_PORT);
    dm_rvalid = done && (owner_reg == DM_PORT);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    dm_rdata  = (dm_rvalid && !store_reg) ? mem_rdata : '0;
  end

  // Two-state access FSM with latency counter and fetch starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= NONE;
      store_reg      <= 1'b0;
      lat_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_if || grant_dm) begin
            owner_reg   <= grant_if ? IF_PORT : DM_PORT;
            store_reg   <= grant_dm && dm_we;
            lat_cnt_reg <= LAT_CNT_W'(1);
            state_reg   <= BUSY;
          end
          // A fetch that is absent or served resets its loss streak
          if (!if_req || grant_if) begin
            starve_cnt_reg <= '0;
          end else if (grant_dm && !starved) begin
            starve_cnt_reg <= starve_cnt_reg + STARVE_CNT_W'(1);
          end
        end
        BUSY: begin
          if (lat_cnt_reg == LAT_CNT_W'(MEM_LAT)) begin
            state_reg   <= IDLE;
            owner_reg   <= NONE;
            store_reg   <= 1'b0;
            lat_cnt_reg <= '0;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + LAT_CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          owner_reg <= NONE;
        end
      endcase
    end
  end

  // Only one requester may ever be granted in a cycle
  a_single_grant: assert property (@(posedge clk) !(if_gnt && dm_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each
// fed by a latency-accurate memory stub, checked every cycle against a
// transaction-level model plus directed literal expectations.
module tb_mem_port_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rst_v, if_req_v, if_gnt_v, if_rvalid_v;
  logic [1:0]         dm_req_v, dm_we_v, dm_gnt_v, dm_rvalid_v, mem_en_v, mem_we_v;
  logic [1:0][AW-1:0] if_addr_v, dm_addr_v, mem_addr_v;
  logic [1:0][DW-1:0] if_rdata_v, dm_wdata_v, dm_rdata_v, mem_wdata_v, mem_rdata_v;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: is an access outstanding, when it answers, for whom, what
  bit             m_busy  [2];
  int             m_done  [2];
  int             m_owner [2];   // 1 = IF, 2 = DM
  logic [DW-1:0]  m_rd    [2];
  int             m_loss  [2];   // consecutive fetch losses

  // Memory contents seen by both instances
  function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
    if (a == 10'h004) return 32'h8C000005;
    return 32'h1000_0000 | {22'd0, a};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;
      logic [7:0]    sr_v;
      logic [AW-1:0] sr_a [8];

      mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
      ) u_dut (
        .clk       (clk),
        .rst       (rst_v[gi]),
        .if_req    (if_req_v[gi]),
        .if_addr   (if_addr_v[gi]),
        .if_gnt    (if_gnt_v[gi]),
        .if_rvalid (if_rvalid_v[gi]),
        .if_rdata  (if_rdata_v[gi]),
        .dm_req    (dm_req_v[gi]),
        .dm_we     (dm_we_v[gi]),
        .dm_addr   (dm_addr_v[gi]),
        .dm_wdata  (dm_wdata_v[gi]),
        .dm_gnt    (dm_gnt_v[gi]),
        .dm_rvalid (dm_rvalid_v[gi]),
        .dm_rdata  (dm_rdata_v[gi]),
        .mem_en    (mem_en_v[gi]),
        .mem_we    (mem_we_v[gi]),
        .mem_addr  (mem_addr_v[gi]),
        .mem_wdata (mem_wdata_v[gi]),
        .mem_rdata (mem_rdata_v[gi])
      );

      // Memory stub: data for a strobe appears exactly LAT cycles later, garbage otherwise
      always @(posedge clk) begin
        sr_v    <= {sr_v[6:0], mem_en_v[gi]};
        sr_a[0] <= mem_addr_v[gi];
        for (int i = 1; i < 8; i++) sr_a[i] <= sr_a[i-1];
      end
      assign mem_rdata_v[gi] = sr_v[LAT-1] ? rd_word(sr_a[LAT-1]) : 32'hBAD0BAD0;
    end
  endgenerate

  // Per-cycle model check of both instances
  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      logic e_ig, e_dg, e_en, e_ir, e_dr, chk_mem, chk_wd, e_we, ok;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_ird, e_drd, e_wd;
      int w;
      e_ig = 0; e_dg = 0; e_en = 0; e_ir = 0; e_dr = 0;
      chk_mem = 0; chk_wd = 0; e_we = 0; e_addr = '0;
      e_ird = '0; e_drd = '0; e_wd = '0; w = 0;
      if (rst_v[k]) begin
        m_busy[k] = 0;
        m_loss[k] = 0;
      end else if (!m_busy[k]) begin
        if (if_req_v[k] || dm_req_v[k]) begin
          w = (if_req_v[k] && (!dm_req_v[k] || m_loss[k] == SMAX)) ? 1 : 2;
          e_en = 1; chk_mem = 1;
          if (w == 1) begin
            e_ig = 1; e_we = 0; e_addr = if_addr_v[k];
            m_rd[k] = rd_word(if_addr_v[k]);
          end else begin
            e_dg = 1; e_we = dm_we_v[k]; e_addr = dm_addr_v[k];
            chk_wd = dm_we_v[k]; e_wd = dm_wdata_v[k];
            m_rd[k] = dm_we_v[k] ? '0 : rd_word(dm_addr_v[k]);
          end
          m_owner[k] = w;
          m_busy[k]  = 1;
          m_done[k]  = cyc + lat_of(k);
        end
        if (!if_req_v[k] || w == 1) m_loss[k] = 0;
        else if (w == 2 && m_loss[k] < SMAX) m_loss[k] = m_loss[k] + 1;
      end else if (cyc == m_done[k]) begin
        if (m_owner[k] == 1) begin e_ir = 1; e_ird = m_rd[k]; end
        else begin e_dr = 1; e_drd = m_rd[k]; end
        m_busy[k] = 0;
      end
      ok = (if_gnt_v[k] === e_ig) && (dm_gnt_v[k] === e_dg) && (mem_en_v[k] === e_en) &&
           (if_rvalid_v[k] === e_ir) && (dm_rvalid_v[k] === e_dr) &&
           (if_rdata_v[k] === e_ird) && (dm_rdata_v[k] === e_drd) &&
           (!chk_mem || ((mem_we_v[k] === e_we) && (mem_addr_v[k] === e_addr))) &&
           (!chk_wd || (mem_wdata_v[k] === e_wd));
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL cycle_model dut%0d cyc=%0d got gnt=%b%b en=%b rv=%b%b ird=%h drd=%h we=%b addr=%h wd=%h required gnt=%b%b en=%b rv=%b%b ird=%h drd=%h we=%b addr=%h wd=%h",
                 k, cyc, if_gnt_v[k], dm_gnt_v[k], mem_en_v[k], if_rvalid_v[k], dm_rvalid_v[k],
                 if_rdata_v[k], dm_rdata_v[k], mem_we_v[k], mem_addr_v[k], mem_wdata_v[k],
                 e_ig, e_dg, e_en, e_ir, e_dr, e_ird, e_drd, e_we, e_addr, e_wd);
      end
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
    $display("check %s cyc=%0d got=%h", name, cyc - 1, got);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin sample(); advance(); end
  endtask

  // Returns just after sampling the grant cycle (or one sample past the budget)
  task automatic wait_gnt(input int k, input bit want_if, input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      sample();
      if (want_if ? if_gnt_v[k] : dm_gnt_v[k]) seen = 1;
      else advance();
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: got no grant in 8 cycles required a grant", name);
      sample();
    end
  endtask

  // Record the grant sequence over n cycles: 1 = IF, 0 = DM, plus gap errors
  task automatic log_grants(input int k, input int n, input int drop_at, input int back_at,
                            output logic [15:0] ord, output int cnt, output int bad_gap);
    int last;
    ord = '0; cnt = 0; bad_gap = 0; last = -1;
    for (int i = 0; i < n; i++) begin
      sample();
      if (if_gnt_v[k] || dm_gnt_v[k]) begin
        ord = {ord[14:0], if_gnt_v[k]};
        if (last >= 0 && i - last != 2) bad_gap++;
        last = i;
        cnt++;
      end
      advance();
      if (i == drop_at) if_req_v[k] = 0;
      if (i == back_at) if_req_v[k] = 1;
    end
  endtask

  initial begin
    logic [15:0] ord;
    int cnt, bad_gap;
    rst_v = 2'b11; if_req_v = '0; dm_req_v = '0; dm_we_v = '0;
    if_addr_v = '0; dm_addr_v = '0; dm_wdata_v = '0;

    // Reset held 3 cycles with both requests high on the MEM_LAT=1 instance
    if_req_v[0] = 1; dm_req_v[0] = 1;
    if_addr_v[0] = 10'h100; dm_addr_v[0] = 10'h200;
    for (int i = 0; i < 3; i++) begin
      sample();
      pin("rst_outputs_zero",
          {54'd0, if_gnt_v[0], dm_gnt_v[0], mem_en_v[0], mem_we_v[0], if_rvalid_v[0],
           dm_rvalid_v[0], |mem_addr_v[0], |mem_wdata_v[0], |if_rdata_v[0], |dm_rdata_v[0]},
          64'd0);
      advance();
    end
    rst_v = 2'b00;
    sample();
    pin("first_gnt_after_rst", {62'd0, if_gnt_v[0], dm_gnt_v[0]}, 64'd1);
    advance();
    if_req_v[0] = 0; dm_req_v[0] = 0;
    idle(2);

    // Fetch only, MEM_LAT=1
    if_addr_v[0] = 10'h004; if_req_v[0] = 1;
    wait_gnt(0, 1'b1, "if_only_gnt");
    pin("if_gnt_mem_en", {52'd0, if_gnt_v[0], mem_en_v[0], mem_addr_v[0]}, {52'd0, 2'b11, 10'h004});
    advance();
    sample();
    pin("if_rvalid_t1", {31'd0, if_rvalid_v[0], if_rdata_v[0]}, {31'd0, 1'b1, 32'h8C000005});
    advance();
    sample();
    pin("if_gnt_t2", {63'd0, if_gnt_v[0]}, 64'd1);
    advance();
    if_req_v[0] = 0;
    idle(3);

    // Both requesting continuously: four DM wins, then a forced IF win
    if_addr_v[0] = 10'h008; dm_addr_v[0] = 10'h020; dm_we_v[0] = 0;
    if_req_v[0] = 1; dm_req_v[0] = 1;
    log_grants(0, 20, -1, -1, ord, cnt, bad_gap);
    if_req_v[0] = 0; dm_req_v[0] = 0;
    pin("conflict_order", {32'd0, cnt[15:0], ord}, {32'd0, 16'd10, 16'b0000_0010_0001});
    pin("conflict_spacing", {32'd0, bad_gap}, 64'd0);
    idle(2);

    // Fetch drops for one IDLE cycle after two losses: streak restarts
    if_req_v[0] = 1; dm_req_v[0] = 1;
    log_grants(0, 16, 3, 4, ord, cnt, bad_gap);
    if_req_v[0] = 0; dm_req_v[0] = 0;
    pin("starve_clear_order", {32'd0, cnt[15:0], ord}, {32'd0, 16'd8, 16'b0000_0000_0000_0001});
    idle(2);

    // Store on the MEM_LAT=3 instance
    dm_we_v[1] = 1; dm_addr_v[1] = 10'h010; dm_wdata_v[1] = 32'h0000002A; dm_req_v[1] = 1;
    wait_gnt(1, 1'b0, "store_gnt");
    pin("store_mem_port", {20'd0, mem_en_v[1], mem_we_v[1], mem_addr_v[1], mem_wdata_v[1]},
        {20'd0, 2'b11, 10'h010, 32'h0000002A});
    advance();
    dm_req_v[1] = 0; dm_we_v[1] = 0;
    sample();
    pin("store_no_rv_t1", {63'd0, dm_rvalid_v[1]}, 64'd0);
    advance();
    idle(1);
    sample();
    pin("store_ack_t3", {31'd0, dm_rvalid_v[1], dm_rdata_v[1]}, {31'd0, 1'b1, 32'd0});
    advance();
    idle(2);

    // Load aborted by reset one cycle after its grant
    dm_addr_v[1] = 10'h030; dm_req_v[1] = 1;
    wait_gnt(1, 1'b0, "mid_load_gnt");
    advance();
    dm_req_v[1] = 0; rst_v[1] = 1;
    sample();
    pin("mid_rst_quiet", {61'd0, dm_rvalid_v[1], dm_gnt_v[1], mem_en_v[1]}, 64'd0);
    advance();
    rst_v[1] = 0; dm_req_v[1] = 1;
    sample();
    pin("regrant_after_rst", {63'd0, dm_gnt_v[1]}, 64'd1);
    advance();
    dm_req_v[1] = 0;
    sample();
    pin("aborted_no_rvalid", {63'd0, dm_rvalid_v[1]}, 64'd0);
    advance();
    idle(1);
    sample();
    pin("regrant_rvalid", {31'd0, dm_rvalid_v[1], dm_rdata_v[1]}, {31'd0, 1'b1, 32'h10000030});
    advance();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
